// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter_pkg
// Brief  : Shared parameters for the register-file write-back path.
//          Register file geometry, default requester count, the fixed
//          requester index assignment and a small ring-increment helper.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

  // Register file geometry: 16 x 24-bit registers, r0 hardwired to zero.
  localparam int RF_ADDR_W  = 4;
  localparam int RF_DATA_W  = 24;

  // Write-back requesters and the width of a requester index.
  localparam int WB_NUM_REQ = 3;
  localparam int WB_GID_W   = 2;

  // Fixed requester slots on the write-back bus.
  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MUL    = 2;

  // Index of the slot after idx on a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter_rr_pick
// Brief  : Combinational round-robin selector. Grants the first set bit of
//          req found by searching upward from ptr and wrapping at N-1 to 0.
// Ports  : req   [N-1:0]     request vector
//          ptr   [IDX_W-1:0] highest-priority index (must be < N)
//          grant [N-1:0]     one-hot grant, zero when req is zero
//          idx   [IDX_W-1:0] binary index of the granted bit
//          found             any request granted
// Rev    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter_rr_pick
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N     = WB_NUM_REQ,
  parameter int IDX_W = WB_GID_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] at_or_above;  // bit i set when i >= ptr
  logic [N-1:0] req_upper;    // requests in the [ptr, N-1] segment
  logic [N-1:0] search_vec;   // segment actually searched

  // Split the ring at ptr: requests at or above ptr win over those below,
  // which gives the wrapped search order ptr..N-1, 0..ptr-1 without any
  // variable rotation.
  always_comb begin
    at_or_above = '0;
    for (int i = 0; i < N; i++) begin
      at_or_above[i] = (IDX_W'(i) >= ptr);
    end
  end

  assign req_upper  = req & at_or_above;
  assign search_vec = (|req_upper) ? req_upper : req;
  assign found      = |req;

  // Lowest set bit of the searched segment. Scanning downward lets the
  // lowest index overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (idx == IDX_W'(i));
    end
  end

endmodule : regfile_wb_arbiter_rr_pick
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Write-back arbiter/sequencer for the single-write-port register
//          file. Grants one requester per cycle in round-robin order and
//          drives the write port from registers so it is stable across the
//          register file's negedge write. Writes to r0 are accepted but
//          never reach the port.
// Ports  : clk, rst_n            clock, async active-low reset
//          req_valid [NUM_REQ]   per-requester request, held until accepted
//          req_addr / req_data   packed per requester (i*W +: W)
//          req_ready [NUM_REQ]   one-hot combinational grant
//          wb_stall              suppresses all grants
//          wr_en/wr_addr/wr_data register file write port
//          wr_gid                requester whose write is on the port
//          busy                  any request pending or a write in flight
// Rev    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int GID_W   = WB_GID_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [GID_W-1:0]          wr_gid,
  output logic                      busy
);

  logic [GID_W-1:0]   rr_ptr;
  logic [GID_W-1:0]   rr_ptr_nxt;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_grant;
  logic [GID_W-1:0]   pick_idx;
  logic               pick_found;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               xfer;

  // Requests are masked while in reset or stalled, so the grant vector
  // itself is zero and a requester can never see a ready it cannot use.
  assign pick_req = (rst_n && !wb_stall) ? req_valid : '0;

  regfile_wb_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (GID_W)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign req_ready = pick_grant;

  // A grant implies valid, so any grant is a transfer on the next edge.
  assign xfer = pick_found;

  // One-hot mux of the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_ptr_nxt = GID_W'(rr_next(int'(pick_idx), NUM_REQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_gid  <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      // r0 is hardwired: the request is consumed but the port stays idle.
      wr_en   <= (sel_addr != '0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_gid  <= pick_idx;
      rr_ptr  <= rr_ptr_nxt;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  assign busy = (|req_valid) || wr_en;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Self-checking bench for regfile_wb_arbiter. A behavioural model
//          (pointer integer, expected register file array) predicts grants
//          and write-port contents; a bench-side register file captures the
//          DUT's negedge writes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 24;
  localparam int GW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb_stall;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [GW-1:0]   wr_gid;
  logic            busy;

  // Per-requester stimulus.
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  // Model state.
  int            m_ptr;
  bit            m_wr_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            last_g;
  logic [DW-1:0] exp_rf [16];
  logic [DW-1:0] rf     [16];

  int checks;
  int failures;

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .GID_W   (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gid    (wr_gid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_valid = v;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  // Bench register file: commits on negedge whatever the port presents.
  // r0 is captured too, so any write to it is visible.
  always @(negedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  // ---------------- reference model ----------------
  function automatic int exp_grant();
    if (!rst_n || wb_stall) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] one;
    g = exp_grant();
    one = 1;
    return (g >= 0) ? (one << g) : '0;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_wr_en = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_gid   = 0;
  endtask

  // Advance one clock; model follows the edge using the inputs presented.
  task automatic step();
    @(posedge clk);
    last_g = exp_grant();
    if (rst_n) begin
      if (last_g >= 0) begin
        m_wr_en = (a[last_g] != 0);
        m_addr  = a[last_g];
        m_data  = d[last_g];
        m_gid   = last_g;
        m_ptr   = (last_g + 1) % N;
        if (a[last_g] != 0) exp_rf[a[last_g]] = d[last_g];
      end else begin
        m_wr_en = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    v        = '0;
    wb_stall = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    v = '1;
    #2;
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++;
    if ({wr_en, wr_addr, wr_data, wr_gid} !== '0) begin
      failures++; $display("FAIL reset_port got en=%b a=%h d=%h g=%0d exp all zero", wr_en, wr_addr, wr_data, wr_gid);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_valid got=%b exp=1", busy); end
    v = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy_idle got=%b exp=0", busy); end
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    v = 3'b001; a[0] = 4'd5; d[0] = 24'hABCDEF;
    #2;
    checks++;
    if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    step();
    v = '0;
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 24'hABCDEF || wr_gid !== 2'd0) begin
      failures++; $display("FAIL single_port got en=%b a=%0d d=%h g=%0d exp en=1 a=5 d=abcdef g=0", wr_en, wr_addr, wr_data, wr_gid);
    end
    step();
    #2;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 4'd5) begin
      failures++; $display("FAIL single_idle got en=%b a=%0d exp en=0 a=5", wr_en, wr_addr);
    end
    checks++;
    if (rf[5] !== 24'hABCDEF) begin failures++; $display("FAIL single_rf5 got=%h exp=abcdef", rf[5]); end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; a[i] = AW'(i + 1); d[i] = DW'($urandom);
    end
    v = '1;
    for (int c = 0; c < 9; c++) begin
      #2;
      checks++;
      if (req_ready !== (3'b001 << (c % 3))) begin
        failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, 3'b001 << (c % 3));
      end
      if (c > 0) begin
        checks++;
        if (wr_en !== 1'b1 || wr_gid !== GW'((c - 1) % 3) || wr_addr !== AW'((c - 1) % 3 + 1) || wr_data !== m_data) begin
          failures++; $display("FAIL rr_port cyc=%0d got en=%b g=%0d a=%0d d=%h exp en=1 g=%0d a=%0d d=%h",
                               c, wr_en, wr_gid, wr_addr, wr_data, (c - 1) % 3, (c - 1) % 3 + 1, m_data);
        end
      end
      step();
      if (last_g >= 0) begin cnt[last_g]++; d[last_g] = DW'($urandom); end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 3) begin failures++; $display("FAIL rr_count req=%0d got=%0d exp=3", i, cnt[i]); end
    end
    v = '0;
  endtask

  task automatic test_reg0();
    do_reset();
    v = 3'b010; a[1] = 4'd0; d[1] = 24'h123456;
    #2;
    checks++;
    if (req_ready !== 3'b010) begin failures++; $display("FAIL r0_ready got=%b exp=010", req_ready); end
    step();
    v = '0;
    #2;
    checks++;
    if (wr_en !== 1'b0) begin failures++; $display("FAIL r0_wr_en got=%b exp=0", wr_en); end
    a[0] = 4'd1; a[1] = 4'd2; a[2] = 4'd3;
    v = '1;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin failures++; $display("FAIL r0_ptr_adv got=%b exp=100", req_ready); end
    v = '0;
    step();
    step();
    #2;
    checks++;
    if (rf[0] !== '0) begin failures++; $display("FAIL r0_rf got=%h exp=000000", rf[0]); end
  endtask

  task automatic test_stall();
    do_reset();
    wb_stall = 1'b1;
    v = 3'b101; a[0] = 4'd4; a[2] = 4'd6; d[0] = DW'($urandom); d[2] = DW'($urandom);
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (req_ready !== '0 || wr_en !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc=%0d got rdy=%b en=%b exp rdy=000 en=0", c, req_ready, wr_en);
      end
      step();
    end
    wb_stall = 1'b0;
    #2;
    checks++;
    if (req_ready !== 3'b001) begin failures++; $display("FAIL stall_rel0 got=%b exp=001", req_ready); end
    step();
    v[0] = 1'b0;
    #2;
    checks++;
    if (req_ready !== 3'b100 || wr_en !== 1'b1 || wr_gid !== 2'd0 || wr_data !== d[0]) begin
      failures++; $display("FAIL stall_rel2 got rdy=%b en=%b g=%0d d=%h exp rdy=100 en=1 g=0 d=%h", req_ready, wr_en, wr_gid, wr_data, d[0]);
    end
    step();
    v = '0;
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_gid !== 2'd2 || wr_addr !== 4'd6) begin
      failures++; $display("FAIL stall_w2 got en=%b g=%0d a=%0d exp en=1 g=2 a=6", wr_en, wr_gid, wr_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a[0] = 4'd8; a[1] = 4'd9; a[2] = 4'd10;
    for (int i = 0; i < N; i++) d[i] = DW'($urandom);
    v = '1;
    step(); d[last_g] = DW'($urandom);
    step(); d[last_g] = DW'($urandom);
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_gid !== 2'd1) begin
      failures++; $display("FAIL mid_pre got en=%b g=%0d exp en=1 g=1", wr_en, wr_gid);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (wr_en !== 1'b0 || req_ready !== '0 || wr_gid !== '0) begin
      failures++; $display("FAIL mid_async got en=%b rdy=%b g=%0d exp en=0 rdy=000 g=0", wr_en, req_ready, wr_gid);
    end
    step();
    rst_n = 1'b1;
    #2;
    checks++;
    if (req_ready !== 3'b001 || wr_en !== 1'b0) begin
      failures++; $display("FAIL mid_regrant got rdy=%b en=%b exp rdy=001 en=0", req_ready, wr_en);
    end
    step();
    v = '0;
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_gid !== 2'd0 || wr_data !== d[0]) begin
      failures++; $display("FAIL mid_write got en=%b g=%0d d=%h exp en=1 g=0 d=%h", wr_en, wr_gid, wr_data, d[0]);
    end
    step();
  endtask

  task automatic test_same_addr();
    do_reset();
    v = 3'b101; a[0] = 4'd7; a[2] = 4'd7; d[0] = 24'h000011; d[2] = 24'h000022;
    #2;
    checks++;
    if (req_ready !== 3'b001) begin failures++; $display("FAIL same_first got=%b exp=001", req_ready); end
    step();
    v[0] = 1'b0;
    #2;
    checks++;
    if (req_ready !== 3'b100 || wr_data !== 24'h000011) begin
      failures++; $display("FAIL same_second got rdy=%b d=%h exp rdy=100 d=000011", req_ready, wr_data);
    end
    step();
    v = '0;
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 24'h000022) begin
      failures++; $display("FAIL same_w2 got en=%b a=%0d d=%h exp en=1 a=7 d=000022", wr_en, wr_addr, wr_data);
    end
    step();
    step();
    checks++;
    if (rf[7] !== 24'h000022) begin failures++; $display("FAIL same_rf7 got=%h exp=000022", rf[7]); end
  endtask

  task automatic test_random();
    int wait_cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      wb_stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1; a[i] = AW'($urandom); d[i] = DW'($urandom);
        end
      end
      #2;
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      checks++;
      if (wr_en !== m_wr_en || wr_addr !== m_addr || wr_data !== m_data || wr_gid !== GW'(m_gid)) begin
        failures++; $display("FAIL rnd_port cyc=%0d got en=%b a=%0d d=%h g=%0d exp en=%b a=%0d d=%h g=%0d",
                             c, wr_en, wr_addr, wr_data, wr_gid, m_wr_en, m_addr, m_data, m_gid);
      end
      checks++;
      if (busy !== ((|v) || m_wr_en)) begin
        failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, (|v) || m_wr_en);
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && !wb_stall) wait_cnt[i]++;
        checks++;
        if (wait_cnt[i] > N) begin
          failures++; $display("FAIL rnd_fair cyc=%0d req=%0d waited=%0d max=%0d", c, i, wait_cnt[i], N);
          wait_cnt[i] = 0;
        end
      end
      step();
      if (last_g >= 0) begin
        v[last_g] = 1'b0;
        wait_cnt[last_g] = 0;
      end
    end
    v = '0;
    wb_stall = 1'b0;
    step();
    step();
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (rf[r] !== exp_rf[r]) begin failures++; $display("FAIL rnd_rf r=%0d got=%h exp=%h", r, rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    wb_stall = 1'b0;
    rst_n    = 1'b0;
    v        = '0;
    last_g   = -1;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    for (int r = 0; r < 16; r++) begin rf[r] = '0; exp_rf[r] = '0; end
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_reg0();
    test_stall();
    test_reset_mid();
    test_same_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
